// File: rtl/qed_i_cache.sv
// QED instruction cache: issues and records fetched instructions (ORIG), then replays them (DUP).
// Optional build macro QIC_OVERFLOW_FLAG_EN adds the sticky qic_overflow output.
module qed_i_cache #(
    parameter int DEPTH  = 16,
    parameter int INSN_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exec_dup,
    input  logic [INSN_W-1:0] ifu_qic_instruction,
    input  logic              ifu_qic_vld,
    input  logic              stall_IF,
    output logic [INSN_W-1:0] qic_qimux_instruction,
    output logic              qic_vld,
    output logic              qic_full,
    output logic              qed_ready
`ifdef QIC_OVERFLOW_FLAG_EN
    ,
    output logic              qic_overflow
`endif
);

    // state | meaning
    // ORIG  | issue fetched instructions and record them in the FIFO
    // DUP   | replay recorded instructions in order; absorbing until reset
    typedef enum logic {ORIG = 1'b0, DUP = 1'b1} state_t;

    localparam int                ADDR_W   = $clog2(DEPTH);
    localparam logic [INSN_W-1:0] NOP      = INSN_W'(32'h0000_0013);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    logic [INSN_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_rptr;
    logic [ADDR_W:0]     r_occ;
    logic [CNT_W-1:0]    r_orig_cnt;
    logic [CNT_W-1:0]    r_dup_cnt;
    logic [INSN_W-1:0]   r_insn;
    logic                r_vld;
    logic                r_ready;

    logic w_dup_now;
    logic w_push;
    logic w_pop;

    // exec_dup takes effect in the same cycle it is seen unstalled
    assign w_dup_now = (r_state == DUP) || exec_dup;
    assign qic_full  = (r_occ == OCC_FULL);
    assign w_push    = !stall_IF && !w_dup_now && ifu_qic_vld && !qic_full;
    assign w_pop     = !stall_IF && w_dup_now && (r_occ != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= ifu_qic_instruction;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ORIG;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_orig_cnt <= '0;
            r_dup_cnt  <= '0;
            r_insn     <= NOP;
            r_vld      <= 1'b0;
            r_ready    <= 1'b0;
        end else if (!stall_IF) begin
            r_insn <= NOP;
            r_vld  <= 1'b0;
            if (w_dup_now) begin
                r_state <= DUP;
            end
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
                r_occ  <= r_occ + (ADDR_W+1)'(1);
                r_insn <= ifu_qic_instruction;
                r_vld  <= 1'b1;
                if (r_orig_cnt != CNT_MAX) begin
                    r_orig_cnt <= r_orig_cnt + CNT_W'(1);
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
                r_occ  <= r_occ - (ADDR_W+1)'(1);
                r_insn <= r_mem[r_rptr];
                r_vld  <= 1'b1;
                if (r_dup_cnt != CNT_MAX) begin
                    r_dup_cnt <= r_dup_cnt + CNT_W'(1);
                end
            end
            if ((r_state == DUP) && (r_occ == '0) && (r_dup_cnt == r_orig_cnt)
                && (r_orig_cnt != '0)) begin
                r_ready <= 1'b1;
            end
        end
    end

    assign qic_qimux_instruction = r_insn;
    assign qic_vld               = r_vld;
    assign qed_ready             = r_ready;

`ifdef QIC_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (!stall_IF) begin
            if ((!w_dup_now && ifu_qic_vld && qic_full) || (r_orig_cnt == CNT_MAX)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign qic_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_qed_i_cache.sv
// Directed self-checking bench for qed_i_cache (DEPTH=16, INSN_W=32, CNT_W=8).
module tb_qed_i_cache;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        exec_dup;
    logic [31:0] ifu_qic_instruction;
    logic        ifu_qic_vld;
    logic        stall_IF;
    logic [31:0] qic_qimux_instruction;
    logic        qic_vld;
    logic        qic_full;
    logic        qed_ready;
`ifdef QIC_OVERFLOW_FLAG_EN
    logic        qic_overflow;
`endif

    int n_chk;
    int n_fail;

    qed_i_cache #(.DEPTH(16), .INSN_W(32), .CNT_W(8)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .exec_dup              (exec_dup),
        .ifu_qic_instruction   (ifu_qic_instruction),
        .ifu_qic_vld           (ifu_qic_vld),
        .stall_IF              (stall_IF),
        .qic_qimux_instruction (qic_qimux_instruction),
        .qic_vld               (qic_vld),
        .qic_full              (qic_full),
`ifdef QIC_OVERFLOW_FLAG_EN
        .qic_overflow          (qic_overflow),
`endif
        .qed_ready             (qed_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] insn, input logic vld);
        chk({tag, "_insn"}, 64'(qic_qimux_instruction), 64'(insn));
        chk({tag, "_vld"}, 64'(qic_vld), 64'(vld));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        exec_dup = 1'b0; ifu_qic_vld = 1'b0; stall_IF = 1'b0; ifu_qic_instruction = '0;
        #1;
        chk("rst_insn", 64'(qic_qimux_instruction), 64'(NOP));
        chk("rst_vld", 64'(qic_vld), 64'd0);
        chk("rst_full", 64'(qic_full), 64'd0);
        chk("rst_ready", 64'(qed_ready), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; exec_dup = 1'b0; ifu_qic_vld = 1'b0; stall_IF = 1'b0;
        ifu_qic_instruction = '0;
        do_reset();

        // three fetches A, B, C in ORIG
        ifu_qic_vld = 1'b1; ifu_qic_instruction = 32'hAAAA_0001; tick(); chk_out("origA", 32'hAAAA_0001, 1'b1);
        ifu_qic_instruction = 32'hBBBB_0002; tick(); chk_out("origB", 32'hBBBB_0002, 1'b1);
        ifu_qic_instruction = 32'hCCCC_0003; tick(); chk_out("origC", 32'hCCCC_0003, 1'b1);
        ifu_qic_vld = 1'b0; tick(); chk_out("orig_idle", NOP, 1'b0);
        chk("orig_cnt3", 64'(dut.r_orig_cnt), 64'd3);
        chk("orig_ready0", 64'(qed_ready), 64'd0);

        // replay, exec_dup dropping back has no effect; fetch ignored in DUP
        exec_dup = 1'b1; tick(); chk_out("dupA", 32'hAAAA_0001, 1'b1);
        exec_dup = 1'b0; ifu_qic_vld = 1'b1; ifu_qic_instruction = 32'hDEAD_BEEF;
        tick(); chk_out("dupB", 32'hBBBB_0002, 1'b1);
        tick(); chk_out("dupC", 32'hCCCC_0003, 1'b1);
        chk("dup_ready_early", 64'(qed_ready), 64'd0);
        tick(); chk_out("dup_empty", NOP, 1'b0);
        chk("dup_ready", 64'(qed_ready), 64'd1);
        tick(); chk_out("dup_empty2", NOP, 1'b0);
        chk("dup_ready_sticky", 64'(qed_ready), 64'd1);

        // fill to 16 and attempt a 17th
        do_reset();
        ifu_qic_vld = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ifu_qic_instruction = 32'h0000_0100 + 32'(i);
            tick();
            chk_out("fill", 32'h0000_0100 + 32'(i), 1'b1);
            chk("fill_full", 64'(qic_full), (i == 15) ? 64'd1 : 64'd0);
        end
        ifu_qic_instruction = 32'h0000_0999; tick();
        chk_out("fill17", NOP, 1'b0);
        chk("fill17_full", 64'(qic_full), 64'd1);
        chk("fill17_cnt", 64'(dut.r_orig_cnt), 64'd16);
`ifdef QIC_OVERFLOW_FLAG_EN
        chk("overflow", 64'(qic_overflow), 64'd1);
`endif

        // replay with a 4-cycle stall and toggling exec_dup in the middle
        ifu_qic_vld = 1'b0; exec_dup = 1'b1; tick(); chk_out("rep0", 32'h100, 1'b1);
        chk("rep0_full", 64'(qic_full), 64'd0);
        exec_dup = 1'b0; tick(); chk_out("rep1", 32'h101, 1'b1);
        stall_IF = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exec_dup = i[0];
            tick();
            chk_out("stall", 32'h101, 1'b1);
            chk("stall_rptr", 64'(dut.r_rptr), 64'd2);
            chk("stall_occ", 64'(dut.r_occ), 64'd14);
        end
        stall_IF = 1'b0; exec_dup = 1'b0;
        for (int i = 2; i < 16; i++) begin
            tick();
            chk_out("rep", 32'h0000_0100 + 32'(i), 1'b1);
        end
        chk("rep_ready_early", 64'(qed_ready), 64'd0);
        tick(); chk_out("rep_end", NOP, 1'b0);
        chk("rep_ready", 64'(qed_ready), 64'd1);

        // exec_dup right after reset: permanent NOP, never ready
        do_reset();
        exec_dup = 1'b1; ifu_qic_vld = 1'b1; ifu_qic_instruction = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            tick();
            exec_dup = 1'b0;
            chk_out("nodup", NOP, 1'b0);
            chk("nodup_ready", 64'(qed_ready), 64'd0);
        end

        // async reset mid-replay with entries pending
        do_reset();
        ifu_qic_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifu_qic_instruction = 32'h0000_0D00 + 32'(i);
            tick();
        end
        ifu_qic_vld = 1'b0; exec_dup = 1'b1;
        tick(); chk_out("mid0", 32'h0D00, 1'b1);
        tick(); chk_out("mid1", 32'h0D01, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("mid_rst", NOP, 1'b0);
        chk("mid_rst_occ", 64'(dut.r_occ), 64'd0);
        chk("mid_rst_ready", 64'(qed_ready), 64'd0);
        exec_dup = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        ifu_qic_vld = 1'b1; ifu_qic_instruction = 32'h0000_0E0E;
        tick(); chk_out("after_rst_orig", 32'h0E0E, 1'b1);
        chk("after_rst_occ", 64'(dut.r_occ), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1);
    end

endmodule
